hazard_ctrl: RTL and testbench

Pipeline control unit that drives the stall and flush inputs of the IF/ID register (if_idWrite, if_flush), plus the PC enable and ID/EX bubble/hold controls.
- Detects load-use hazards between ID and EX.
- Flushes on branches resolved taken in EX.
- Freezes the front end while a multi-cycle EX operation (mul/div) occupies EX.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, taken-branch flush, multi-cycle EX freeze, stall counter.
// Latency: control outputs are combinational from state and inputs; state and counters update on the next edge.
// Backpressure: holds PC and IF/ID for one cycle on load-use, and for MC_LATENCY-1 cycles while a mul/div occupies EX.
module hazard_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             id_mc_op,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_idWrite,
    output logic             if_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    // A single-cycle "multi-cycle" op needs no freeze, so the busy state is never used.
    localparam bit         MC_EN   = (MC_LATENCY > 1);
    localparam logic [7:0] MC_LOAD = 8'(MC_LATENCY - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_mc_cnt;
    logic [7:0]         w_mc_cnt_nxt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_load_use;

    // EX load writes a register the ID instruction actually reads; x0 is never a real dependency.
    assign w_load_use = ex_mem_read & (ex_rd != 5'd0) &
                        ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

    // State and multi-cycle down-counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_mc_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
        end
    end

    // Next-state and control outputs; reset forces NOPs into IF/ID and ID/EX.
    always_comb begin
        pc_write     = 1'b1;
        if_idWrite   = 1'b1;
        if_flush     = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        mc_busy      = 1'b0;
        w_state_nxt  = r_state;
        w_mc_cnt_nxt = r_mc_cnt;

        if (!rst_n) begin
            pc_write     = 1'b0;
            if_flush     = 1'b1;
            id_ex_bubble = 1'b1;
            w_state_nxt  = RUN;
            w_mc_cnt_nxt = 8'd0;
        end else if (r_state == MC_BUSY) begin
            // EX holds a non-branch, non-load op, so branch and load-use are irrelevant here.
            pc_write   = 1'b0;
            if_idWrite = 1'b0;
            ex_hold    = 1'b1;
            mc_busy    = 1'b1;
            if (r_mc_cnt <= 8'd1) begin
                w_state_nxt  = RUN;
                w_mc_cnt_nxt = 8'd0;
            end else begin
                w_mc_cnt_nxt = r_mc_cnt - 8'd1;
            end
        end else begin
            if (branch_taken) begin
                // IF/ID keeps write enabled: hold would beat the flush otherwise.
                if_flush     = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (w_load_use) begin
                // One-cycle stall; the EX bubble removes the hazard next cycle.
                pc_write     = 1'b0;
                if_idWrite   = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (id_mc_op && MC_EN) begin
                w_state_nxt  = MC_BUSY;
                w_mc_cnt_nxt = MC_LOAD;
            end
        end
    end

    // Saturating count of cycles in which IF/ID was held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!if_idWrite && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: default, CNT_W=4 and MC_LATENCY=1 instances share stimulus.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the falling edge.
// Expected values are pushed to scoreboard queues as stimulus is applied and popped at sampling.
module tb_hazard_ctrl;

    // Control vector order: {pc_write, if_idWrite, if_flush, id_ex_bubble, ex_hold, mc_busy}
    localparam logic [5:0] C_RESET = 6'b011100;
    localparam logic [5:0] C_RUN   = 6'b110000;
    localparam logic [5:0] C_LU    = 6'b000100;
    localparam logic [5:0] C_BR    = 6'b111100;
    localparam logic [5:0] C_BUSY  = 6'b000011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs2, id_mc_op, ex_mem_read, branch_taken;

    logic        m_pc, m_ifw, m_fl, m_bub, m_hold, m_busy;
    logic [15:0] m_cnt;
    logic        s_pc, s_ifw, s_fl, s_bub, s_hold, s_busy;
    logic [3:0]  s_cnt;
    logic        l_pc, l_ifw, l_fl, l_bub, l_hold, l_busy;
    logic [15:0] l_cnt;

    int tests  = 0;
    int failed = 0;

    logic [5:0]  q_ctrl[$];
    logic [15:0] q_cnt[$];
    logic [5:0]  e_ctrl;
    logic [15:0] e_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MC_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_mc_op(id_mc_op), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .pc_write(m_pc), .if_idWrite(m_ifw), .if_flush(m_fl), .id_ex_bubble(m_bub),
        .ex_hold(m_hold), .mc_busy(m_busy), .stall_cnt(m_cnt)
    );

    hazard_ctrl #(.MC_LATENCY(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_mc_op(id_mc_op), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .pc_write(s_pc), .if_idWrite(s_ifw), .if_flush(s_fl), .id_ex_bubble(s_bub),
        .ex_hold(s_hold), .mc_busy(s_busy), .stall_cnt(s_cnt)
    );

    hazard_ctrl #(.MC_LATENCY(1), .CNT_W(16)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_mc_op(id_mc_op), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .pc_write(l_pc), .if_idWrite(l_ifw), .if_flush(l_fl), .id_ex_bubble(l_bub),
        .ex_hold(l_hold), .mc_busy(l_busy), .stall_cnt(l_cnt)
    );

    function automatic logic [5:0] obs_m();
        return {m_pc, m_ifw, m_fl, m_bub, m_hold, m_busy};
    endfunction
    function automatic logic [5:0] obs_s();
        return {s_pc, s_ifw, s_fl, s_bub, s_hold, s_busy};
    endfunction
    function automatic logic [5:0] obs_l();
        return {l_pc, l_ifw, l_fl, l_bub, l_hold, l_busy};
    endfunction

    task automatic drive_idle();
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs2 = 1'b0; id_mc_op = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; branch_taken = 1'b0;
    endtask

    task automatic drive_lu(input logic [4:0] rd);
        drive_idle();
        ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; drive_lu(5'd5); branch_taken = 1'b1; id_mc_op = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            q_ctrl.push_back(C_RESET); q_cnt.push_back(16'd0);
            @(negedge clk);
            e_ctrl = q_ctrl.pop_front(); e_cnt = q_cnt.pop_front(); tests += 2;
            if (obs_m() !== e_ctrl) begin failed++; $display("FAIL reset_ctrl c%0d: got %b want %b", c, obs_m(), e_ctrl); end
            if (m_cnt !== e_cnt) begin failed++; $display("FAIL reset_cnt c%0d: got %0d want %0d", c, m_cnt, e_cnt); end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; drive_idle();
        q_ctrl.push_back(C_RUN); q_cnt.push_back(16'd0);
        @(negedge clk);
        e_ctrl = q_ctrl.pop_front(); e_cnt = q_cnt.pop_front(); tests += 2;
        if (obs_m() !== e_ctrl) begin failed++; $display("FAIL reset_release_ctrl: got %b want %b", obs_m(), e_ctrl); end
        if (m_cnt !== e_cnt) begin failed++; $display("FAIL reset_release_cnt: got %0d want %0d", m_cnt, e_cnt); end
    endtask

    task automatic test_load_use();
        @(posedge clk); #1;
        drive_lu(5'd5);
        q_ctrl.push_back(C_LU);
        @(negedge clk);
        e_ctrl = q_ctrl.pop_front(); tests++;
        if (obs_m() !== e_ctrl) begin failed++; $display("FAIL load_use_ctrl: got %b want %b", obs_m(), e_ctrl); end
        // Hazard removed by the bubble: model EX now holds a NOP.
        @(posedge clk); #1;
        drive_idle();
        q_ctrl.push_back(C_RUN); q_cnt.push_back(16'd1);
        @(negedge clk);
        e_ctrl = q_ctrl.pop_front(); e_cnt = q_cnt.pop_front(); tests += 2;
        if (obs_m() !== e_ctrl) begin failed++; $display("FAIL load_use_release: got %b want %b", obs_m(), e_ctrl); end
        if (m_cnt !== e_cnt) begin failed++; $display("FAIL load_use_cnt: got %0d want %0d", m_cnt, e_cnt); end
    endtask

    task automatic test_filter();
        logic [4:0] t_rd[3]  = '{5'd0, 5'd7, 5'd7};
        logic [4:0] t_rs1[3] = '{5'd0, 5'd3, 5'd3};
        logic       t_use[3] = '{1'b0, 1'b0, 1'b1};
        logic [5:0] t_exp[3] = '{C_RUN, C_RUN, C_LU};
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive_idle();
            ex_mem_read = 1'b1; ex_rd = t_rd[k]; id_rs1 = t_rs1[k]; id_rs2 = 5'd7; id_uses_rs2 = t_use[k];
            q_ctrl.push_back(t_exp[k]);
            @(negedge clk);
            e_ctrl = q_ctrl.pop_front(); tests++;
            if (obs_m() !== e_ctrl) begin failed++; $display("FAIL filter_case%0d: got %b want %b", k, obs_m(), e_ctrl); end
        end
        @(posedge clk); #1;
        drive_idle();
        q_cnt.push_back(16'd2);
        @(negedge clk);
        e_cnt = q_cnt.pop_front(); tests++;
        if (m_cnt !== e_cnt) begin failed++; $display("FAIL filter_cnt: got %0d want %0d", m_cnt, e_cnt); end
    endtask

    task automatic test_branch();
        @(posedge clk); #1;
        drive_lu(5'd9); branch_taken = 1'b1; id_mc_op = 1'b1;
        q_ctrl.push_back(C_BR);
        @(negedge clk);
        e_ctrl = q_ctrl.pop_front(); tests++;
        if (obs_m() !== e_ctrl) begin failed++; $display("FAIL branch_ctrl: got %b want %b", obs_m(), e_ctrl); end
        // mc_op must have been dropped by the branch: next cycle is RUN, not busy.
        @(posedge clk); #1;
        drive_idle();
        q_ctrl.push_back(C_RUN); q_cnt.push_back(16'd2);
        @(negedge clk);
        e_ctrl = q_ctrl.pop_front(); e_cnt = q_cnt.pop_front(); tests += 2;
        if (obs_m() !== e_ctrl) begin failed++; $display("FAIL branch_after: got %b want %b", obs_m(), e_ctrl); end
        if (m_cnt !== e_cnt) begin failed++; $display("FAIL branch_cnt: got %0d want %0d", m_cnt, e_cnt); end
    endtask

    task automatic test_multicycle();
        logic [5:0] t_exp[5] = '{C_RUN, C_BUSY, C_BUSY, C_BUSY, C_RUN};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            drive_idle();
            if (k == 0) id_mc_op = 1'b1;
            if (k == 2) begin drive_lu(5'd4); branch_taken = 1'b1; end
            q_ctrl.push_back(t_exp[k]);
            @(negedge clk);
            e_ctrl = q_ctrl.pop_front(); tests++;
            if (obs_m() !== e_ctrl) begin failed++; $display("FAIL mc_cycle%0d: got %b want %b", k, obs_m(), e_ctrl); end
        end
        q_cnt.push_back(16'd5);
        e_cnt = q_cnt.pop_front(); tests++;
        if (m_cnt !== e_cnt) begin failed++; $display("FAIL mc_cnt: got %0d want %0d", m_cnt, e_cnt); end
    endtask

    task automatic test_latency1();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            drive_idle();
            if (k == 0) id_mc_op = 1'b1;
            q_ctrl.push_back(C_RUN);
            @(negedge clk);
            e_ctrl = q_ctrl.pop_front(); tests++;
            if (obs_l() !== e_ctrl) begin failed++; $display("FAIL lat1_cycle%0d: got %b want %b", k, obs_l(), e_ctrl); end
        end
        q_cnt.push_back(16'd2);
        e_cnt = q_cnt.pop_front(); tests++;
        if (l_cnt !== e_cnt) begin failed++; $display("FAIL lat1_cnt: got %0d want %0d", l_cnt, e_cnt); end
    endtask

    task automatic test_reset_mid_busy();
        logic [5:0] t_exp[4] = '{C_RUN, C_BUSY, C_RESET, C_RUN};
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            drive_idle();
            rst_n = (k == 2) ? 1'b0 : 1'b1;
            if (k == 0) id_mc_op = 1'b1;
            q_ctrl.push_back(t_exp[k]);
            @(negedge clk);
            e_ctrl = q_ctrl.pop_front(); tests++;
            if (obs_m() !== e_ctrl) begin failed++; $display("FAIL rst_busy_cycle%0d: got %b want %b", k, obs_m(), e_ctrl); end
        end
        q_cnt.push_back(16'd0);
        e_cnt = q_cnt.pop_front(); tests++;
        if (m_cnt !== e_cnt) begin failed++; $display("FAIL rst_busy_cnt: got %0d want %0d", m_cnt, e_cnt); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            drive_lu(5'd6);
            q_ctrl.push_back(C_LU);
            q_cnt.push_back((i > 15) ? 16'd15 : 16'(i));
            @(negedge clk);
            e_ctrl = q_ctrl.pop_front(); e_cnt = q_cnt.pop_front(); tests += 2;
            if (obs_s() !== e_ctrl) begin failed++; $display("FAIL sat_ctrl%0d: got %b want %b", i, obs_s(), e_ctrl); end
            if ({12'd0, s_cnt} !== e_cnt) begin failed++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, s_cnt, e_cnt); end
        end
        @(posedge clk); #1;
        drive_idle();
        q_cnt.push_back(16'd15); q_cnt.push_back(16'd20);
        @(negedge clk);
        e_cnt = q_cnt.pop_front(); tests++;
        if ({12'd0, s_cnt} !== e_cnt) begin failed++; $display("FAIL sat_final: got %0d want %0d", s_cnt, e_cnt); end
        e_cnt = q_cnt.pop_front(); tests++;
        if (m_cnt !== e_cnt) begin failed++; $display("FAIL wide_cnt_final: got %0d want %0d", m_cnt, e_cnt); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_load_use();
        test_filter();
        test_branch();
        test_multicycle();
        test_latency1();
        test_reset_mid_busy();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
